// File: rtl/jtframe_romrd_pkg.sv
// Shared types and constants for the two-slot SDRAM ROM reader.
// The optional watchdog is enabled with JTFRAME_ROMRD_TIMEOUT_EN.
package jtframe_romrd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_ACK  = 2'd1,
      ST_WAIT_DATA = 2'd2
   } state_t;

   localparam int         SDRAM_AW = 22;
   localparam logic [7:0] WD_LIMIT = 8'd255;

   // Number of address bits that select a lane inside the 32-bit word
   function automatic int lane_bits(input int dw);
      return (dw == 8) ? 2 : 1;
   endfunction

endpackage

// File: rtl/jtframe_romrd_slot.sv
// One ROM slot: 32-bit single-word cache, tag, valid and pending flags,
// combinational hit detection and lane selection.
module jtframe_romrd_slot
   import jtframe_romrd_pkg::*;
#(
   parameter int AW = 17,
   parameter int DW = 8
)(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          flush,
   input  logic                          cs,
   input  logic [AW-1:0]                 addr,
   output logic [DW-1:0]                 dout,
   output logic                          ok,
   output logic [AW-lane_bits(DW)-1:0]   word_addr,
   output logic                          pending,
   input  logic                          fill,
   input  logic [AW-lane_bits(DW)-1:0]   fill_tag,
   input  logic [31:0]                   fill_data
);

   localparam int LB  = lane_bits(DW);
   localparam int WAW = AW - LB;

   logic [31:0]    cache;
   logic [WAW-1:0] tag;
   logic           valid;
   logic           hit;
   logic [31:0]    shifted;

   assign word_addr = addr[AW-1:LB];
   assign hit       = cs & valid & (tag == word_addr);
   assign ok        = hit;
   // Lane 0 sits in the low bits; dout follows the cache even when not ok
   assign shifted   = cache >> (DW * int'(addr[LB-1:0]));
   assign dout      = shifted[DW-1:0];

   // Cache fill, flush on download, and miss tracking
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cache   <= '0;
         tag     <= '0;
         valid   <= 1'b0;
         pending <= 1'b0;
      end else if (flush) begin
         valid   <= 1'b0;
         pending <= 1'b0;
      end else if (fill) begin
         // Filled with the fetched tag even if addr moved meanwhile;
         // a fresh miss will then raise pending again next cycle.
         cache   <= fill_data;
         tag     <= fill_tag;
         valid   <= 1'b1;
         pending <= 1'b0;
      end else if (cs && !hit) begin
         pending <= 1'b1;
      end
   end

endmodule

// File: rtl/jtframe_romrd_2slot.sv
// Two-slot game ROM reader on a shared SDRAM read port: per-slot word
// cache, round-robin miss arbiter and a request/ack/data FSM.
// Optional watchdog on WAIT_DATA: define JTFRAME_ROMRD_TIMEOUT_EN.
// Handshake: sdram_req is held high with a stable sdram_addr until the
// one-cycle sdram_ack pulse; the word then arrives with a one-cycle
// data_rdy pulse. Pulses outside their waiting state are ignored.
module jtframe_romrd_2slot
   import jtframe_romrd_pkg::*;
#(
   parameter int          AW0     = 17,
   parameter int          DW0     = 8,
   parameter int          AW1     = 15,
   parameter int          DW1     = 16,
   parameter logic [21:0] OFFSET0 = 22'h0,
   parameter logic [21:0] OFFSET1 = 22'h0
)(
   input  logic                clk,
   input  logic                rst,
   input  logic                downloading,
   input  logic                slot0_cs,
   input  logic [AW0-1:0]      slot0_addr,
   output logic [DW0-1:0]      slot0_dout,
   output logic                slot0_ok,
   input  logic                slot1_cs,
   input  logic [AW1-1:0]      slot1_addr,
   output logic [DW1-1:0]      slot1_dout,
   output logic                slot1_ok,
   output logic                sdram_req,
   output logic [SDRAM_AW-1:0] sdram_addr,
   input  logic                sdram_ack,
   input  logic                data_rdy,
   input  logic [31:0]         data_read
`ifdef JTFRAME_ROMRD_TIMEOUT_EN
   ,output logic [7:0]         timeout_cnt
`endif
);

   localparam int WAW0 = AW0 - lane_bits(DW0);
   localparam int WAW1 = AW1 - lane_bits(DW1);

   state_t              state, state_nx;
   logic                req_nx;
   logic [SDRAM_AW-1:0] addr_nx;
   logic                fetch_sel, sel_nx;
   logic [SDRAM_AW-1:0] fetch_tag, tag_nx;
   logic                last, last_nx;
   logic                grant;
   logic                fill0, fill1;
   logic                pend0, pend1;
   logic [WAW0-1:0]     word0;
   logic [WAW1-1:0]     word1;
`ifdef JTFRAME_ROMRD_TIMEOUT_EN
   logic [7:0]          wd, wd_nx;
   logic [7:0]          tcnt_nx;
`endif

   jtframe_romrd_slot #(.AW(AW0), .DW(DW0)) u_slot0 (
      .clk       (clk),
      .rst       (rst),
      .flush     (downloading),
      .cs        (slot0_cs),
      .addr      (slot0_addr),
      .dout      (slot0_dout),
      .ok        (slot0_ok),
      .word_addr (word0),
      .pending   (pend0),
      .fill      (fill0),
      .fill_tag  (fetch_tag[WAW0-1:0]),
      .fill_data (data_read)
   );

   jtframe_romrd_slot #(.AW(AW1), .DW(DW1)) u_slot1 (
      .clk       (clk),
      .rst       (rst),
      .flush     (downloading),
      .cs        (slot1_cs),
      .addr      (slot1_addr),
      .dout      (slot1_dout),
      .ok        (slot1_ok),
      .word_addr (word1),
      .pending   (pend1),
      .fill      (fill1),
      .fill_tag  (fetch_tag[WAW1-1:0]),
      .fill_data (data_read)
   );

   // State and registered SDRAM request outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         sdram_req   <= 1'b0;
         sdram_addr  <= '0;
         fetch_sel   <= 1'b0;
         fetch_tag   <= '0;
         last        <= 1'b1;   // slot 0 wins the first tie
`ifdef JTFRAME_ROMRD_TIMEOUT_EN
         wd          <= '0;
         timeout_cnt <= '0;
`endif
      end else begin
         state       <= state_nx;
         sdram_req   <= req_nx;
         sdram_addr  <= addr_nx;
         fetch_sel   <= sel_nx;
         fetch_tag   <= tag_nx;
         last        <= last_nx;
`ifdef JTFRAME_ROMRD_TIMEOUT_EN
         wd          <= wd_nx;
         timeout_cnt <= tcnt_nx;
`endif
      end
   end

   // Next-state, arbitration and fill strobes
   always_comb begin
      state_nx = state;
      req_nx   = sdram_req;
      addr_nx  = sdram_addr;
      sel_nx   = fetch_sel;
      tag_nx   = fetch_tag;
      last_nx  = last;
      grant    = 1'b0;
      fill0    = 1'b0;
      fill1    = 1'b0;
`ifdef JTFRAME_ROMRD_TIMEOUT_EN
      wd_nx    = wd;
      tcnt_nx  = timeout_cnt;
`endif
      case (state)
         ST_IDLE: begin
            if (pend0 || pend1) begin
               // On a tie, serve the slot that was not served last
               grant    = (pend0 && pend1) ? ~last : pend1;
               sel_nx   = grant;
               last_nx  = grant;
               tag_nx   = grant ? SDRAM_AW'(word1) : SDRAM_AW'(word0);
               addr_nx  = grant ? OFFSET1 + (SDRAM_AW'(word1) << 1)
                                : OFFSET0 + (SDRAM_AW'(word0) << 1);
               req_nx   = 1'b1;
               state_nx = ST_WAIT_ACK;
            end
         end
         ST_WAIT_ACK: begin
            if (sdram_ack) begin
               req_nx   = 1'b0;
               state_nx = ST_WAIT_DATA;
`ifdef JTFRAME_ROMRD_TIMEOUT_EN
               wd_nx    = '0;
`endif
            end
         end
         ST_WAIT_DATA: begin
            if (data_rdy) begin
               fill0    = ~fetch_sel;
               fill1    = fetch_sel;
               state_nx = ST_IDLE;
            end
`ifdef JTFRAME_ROMRD_TIMEOUT_EN
            else if (wd == WD_LIMIT) begin
               // Give up; pending stays set so the read is re-issued
               state_nx = ST_IDLE;
               if (timeout_cnt != 8'hFF) tcnt_nx = timeout_cnt + 8'd1;
            end else begin
               wd_nx = wd + 8'd1;
            end
`endif
         end
         default: state_nx = ST_IDLE;
      endcase
      if (downloading) begin
         state_nx = ST_IDLE;
         req_nx   = 1'b0;
         fill0    = 1'b0;
         fill1    = 1'b0;
      end
   end

endmodule

// File: tb/tb_jtframe_romrd_2slot.sv
// Self-checking bench for jtframe_romrd_2slot: directed steps followed by
// randomized reads served by a behavioural SDRAM model.
// Extra watchdog steps compile in with JTFRAME_ROMRD_TIMEOUT_EN.
module tb_jtframe_romrd_2slot;

   localparam logic [21:0] OFF0 = 22'h100;
   localparam logic [21:0] OFF1 = 22'h2000;

   logic        clk = 1'b0;
   logic        rst;
   logic        downloading;
   logic        slot0_cs;
   logic [16:0] slot0_addr;
   logic [7:0]  slot0_dout;
   logic        slot0_ok;
   logic        slot1_cs;
   logic [14:0] slot1_addr;
   logic [15:0] slot1_dout;
   logic        slot1_ok;
   logic        sdram_req;
   logic [21:0] sdram_addr;
   logic        sdram_ack;
   logic        data_rdy;
   logic [31:0] data_read;
`ifdef JTFRAME_ROMRD_TIMEOUT_EN
   logic [7:0]  timeout_cnt;
`endif

   int errors = 0;
   int checks = 0;

   jtframe_romrd_2slot #(
      .AW0(17), .DW0(8), .AW1(15), .DW1(16), .OFFSET0(OFF0), .OFFSET1(OFF1)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .downloading (downloading),
      .slot0_cs    (slot0_cs),
      .slot0_addr  (slot0_addr),
      .slot0_dout  (slot0_dout),
      .slot0_ok    (slot0_ok),
      .slot1_cs    (slot1_cs),
      .slot1_addr  (slot1_addr),
      .slot1_dout  (slot1_dout),
      .slot1_ok    (slot1_ok),
      .sdram_req   (sdram_req),
      .sdram_addr  (sdram_addr),
      .sdram_ack   (sdram_ack),
      .data_rdy    (data_rdy),
      .data_read   (data_read)
`ifdef JTFRAME_ROMRD_TIMEOUT_EN
      ,.timeout_cnt (timeout_cnt)
`endif
   );

   // Clock
   always #5 clk = ~clk;

   // Hard stop in case something hangs outside the bounded waits
   initial begin
      #2000000;
      $display("FAIL global_timeout observed=hang expected=finish");
      $fatal(1, "simulation time limit");
   end

   // SDRAM contents model: one 16-bit value per address
   function automatic logic [15:0] mem16(input logic [21:0] a);
      return a[15:0] ^ {a[7:0], a[15:8]} ^ {10'd0, a[21:16]} ^ 16'h5A3C;
   endfunction

   function automatic logic [31:0] mem_word(input logic [21:0] a);
      return {mem16(a + 22'd1), mem16(a)};
   endfunction

   // Byte-wide slot 0: byte a lives in 16-bit word OFF0 + a/2
   function automatic logic [7:0] exp0(input logic [16:0] a);
      logic [15:0] w;
      w = mem16(OFF0 + 22'(a >> 1));
      return a[0] ? w[15:8] : w[7:0];
   endfunction

   // 16-bit slot 1: halfword a lives at OFF1 + a
   function automatic logic [15:0] exp1(input logic [14:0] a);
      return mem16(OFF1 + 22'(a));
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_req(input int limit);
      int n = 0;
      while (!sdram_req && n < limit) begin
         @(negedge clk);
         n++;
      end
      check("req_rise", sdram_req, 1'b1);
   endtask

   // Serve one SDRAM read with ack and data each one cycle apart
   task automatic do_fetch(output logic [21:0] a);
      wait_req(30);
      a = sdram_addr;
      sdram_ack = 1'b1;
      @(negedge clk);
      sdram_ack = 1'b0;
      data_rdy  = 1'b1;
      data_read = mem_word(a);
      @(negedge clk);
      data_rdy  = 1'b0;
   endtask

   logic [21:0] got;
   logic [21:0] resp_addr;
   int          phase;
   logic        done;

   initial begin
      rst = 1'b1; downloading = 1'b0;
      slot0_cs = 1'b0; slot0_addr = '0; slot1_cs = 1'b0; slot1_addr = '0;
      sdram_ack = 1'b0; data_rdy = 1'b0; data_read = '0;

      // Reset values
      repeat (2) @(negedge clk);
      check("rst_req", sdram_req, 1'b0);
      check("rst_addr", sdram_addr, 22'h0);
      check("rst_ok0", slot0_ok, 1'b0);
      check("rst_dout0", slot0_dout, 8'h0);
      check("rst_dout1", slot1_dout, 16'h0);
      rst = 1'b0;
      @(negedge clk);

      // Byte slot miss, exact latency, then a hit in the same word
      slot0_cs = 1'b1; slot0_addr = 17'h5;
      @(negedge clk);
      check("miss_req_early", sdram_req, 1'b0);
      @(negedge clk);
      check("miss_req", sdram_req, 1'b1);
      check("miss_addr", sdram_addr, 22'h102);
      check("miss_ok_low", slot0_ok, 1'b0);
      sdram_ack = 1'b1;
      @(negedge clk);
      sdram_ack = 1'b0;
      check("req_drop_on_ack", sdram_req, 1'b0);
      data_rdy = 1'b1; data_read = 32'hDDCCBBAA;
      @(negedge clk);
      data_rdy = 1'b0;
      check("fill_ok0", slot0_ok, 1'b1);
      check("fill_dout0", slot0_dout, 8'hBB);
      slot0_addr = 17'h7;
      #1;
      check("hit_ok0", slot0_ok, 1'b1);
      check("hit_dout0", slot0_dout, 8'hDD);
      slot0_addr = 17'h20;

      // Reset in the middle of a fetch, then a stray data_rdy
      wait_req(30);
      rst = 1'b1; slot0_addr = 17'h7;
      #1;
      check("midrst_req", sdram_req, 1'b0);
      check("midrst_addr", sdram_addr, 22'h0);
      check("midrst_ok0", slot0_ok, 1'b0);
      check("midrst_dout0", slot0_dout, 8'h0);
      slot0_cs = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      data_rdy = 1'b1; data_read = 32'h12345678;
      @(negedge clk);
      data_rdy = 1'b0;
      slot0_cs = 1'b1;
      #1;
      check("stray_ok0", slot0_ok, 1'b0);
      check("stray_dout0", slot0_dout, 8'h0);
      check("stray_req", sdram_req, 1'b0);
      slot0_cs = 1'b0;
      @(negedge clk);

      // Both miss after reset: slot 0 first, then slot 1
      slot0_cs = 1'b1; slot0_addr = 17'h20;
      slot1_cs = 1'b1; slot1_addr = 15'h4;
      do_fetch(got);
      check("arb1_first", got, OFF0 + 22'h10);
      check("arb1_ok0", slot0_ok, 1'b1);
      check("arb1_dout0", slot0_dout, exp0(17'h20));
      check("arb1_ok1", slot1_ok, 1'b0);
      do_fetch(got);
      check("arb1_second", got, OFF1 + 22'h4);
      check("arb1_dout1", slot1_dout, exp1(15'h4));

      // Slot 0 alone, then both miss: slot 1 goes first this time
      slot0_addr = 17'h44;
      do_fetch(got);
      check("solo0_addr", got, OFF0 + 22'h22);
      check("solo0_dout", slot0_dout, exp0(17'h44));
      slot0_addr = 17'h60; slot1_addr = 15'h10;
      do_fetch(got);
      check("arb2_first", got, OFF1 + 22'h10);
      do_fetch(got);
      check("arb2_second", got, OFF0 + 22'h30);
      check("arb2_ok0", slot0_ok, 1'b1);
      check("arb2_ok1", slot1_ok, 1'b1);
      check("arb2_dout1", slot1_dout, exp1(15'h10));

      // Slot 1 address moves while the fetch is in flight
      slot0_cs = 1'b0;
      slot1_addr = 15'h3;
      wait_req(30);
      check("move_addr1", sdram_addr, OFF1 + 22'h2);
      got = sdram_addr;
      sdram_ack = 1'b1;
      @(negedge clk);
      sdram_ack = 1'b0;
      slot1_addr = 15'h8;
      data_rdy = 1'b1; data_read = mem_word(got);
      @(negedge clk);
      data_rdy = 1'b0;
      check("move_ok_low", slot1_ok, 1'b0);
      slot1_addr = 15'h3;
      #1;
      check("move_old_line", slot1_ok, 1'b1);
      check("move_old_dout", slot1_dout, exp1(15'h3));
      slot1_addr = 15'h8;
      do_fetch(got);
      check("move_refetch", got, OFF1 + 22'h8);
      check("move_dout1", slot1_dout, exp1(15'h8));

      // Download during WAIT_ACK flushes everything
      slot0_cs = 1'b1; slot0_addr = 17'h60;
      #1;
      check("pre_dl_ok0", slot0_ok, 1'b1);
      slot0_addr = 17'h80;
      wait_req(30);
      downloading = 1'b1;
      @(negedge clk);
      downloading = 1'b0;
      check("dl_req", sdram_req, 1'b0);
      slot0_addr = 17'h60;
      #1;
      check("dl_ok0", slot0_ok, 1'b0);
      check("dl_ok1", slot1_ok, 1'b0);
      slot0_cs = 1'b0; slot1_cs = 1'b0;
      sdram_ack = 1'b1;
      @(negedge clk);
      sdram_ack = 1'b0;
      data_rdy = 1'b1; data_read = mem_word(OFF0 + 22'h40);
      @(negedge clk);
      data_rdy = 1'b0;
      slot0_cs = 1'b1; slot0_addr = 17'h80;
      #1;
      check("dl_stray_ok0", slot0_ok, 1'b0);
      check("dl_stray_req", sdram_req, 1'b0);
      slot0_cs = 1'b0;
      @(negedge clk);

      // Randomized reads against the memory model
      for (int it = 0; it < 40; it++) begin
         slot0_cs   = 1'($urandom_range(0, 1));
         slot1_cs   = 1'($urandom_range(0, 1));
         slot0_addr = 17'($urandom_range(0, 63));
         slot1_addr = 15'($urandom_range(0, 31));
         phase = 0;
         done  = 1'b0;
         for (int c = 0; c < 80 && !done; c++) begin
            @(negedge clk);
            sdram_ack = 1'b0;
            data_rdy  = 1'b0;
            if (slot0_cs && slot0_ok) check("rnd_dout0", slot0_dout, exp0(slot0_addr));
            if (slot1_cs && slot1_ok) check("rnd_dout1", slot1_dout, exp1(slot1_addr));
            if ((!slot0_cs || slot0_ok) && (!slot1_cs || slot1_ok)) begin
               done = 1'b1;
            end else if (phase == 0 && sdram_req && $urandom_range(0, 1) == 1) begin
               sdram_ack = 1'b1;
               resp_addr = sdram_addr;
               phase = 1;
            end else if (phase == 1 && $urandom_range(0, 1) == 1) begin
               data_rdy  = 1'b1;
               data_read = mem_word(resp_addr);
               phase = 0;
            end
         end
         check("rnd_done", done, 1'b1);
      end
      sdram_ack = 1'b0; data_rdy = 1'b0;
      slot0_cs = 1'b0; slot1_cs = 1'b0;
      @(negedge clk);

`ifdef JTFRAME_ROMRD_TIMEOUT_EN
      // Lost data_rdy: watchdog returns to IDLE and re-issues the read
      slot0_cs = 1'b1; slot0_addr = 17'hA0;
      wait_req(30);
      got = sdram_addr;
      sdram_ack = 1'b1;
      @(negedge clk);
      sdram_ack = 1'b0;
      for (int c = 0; c < 300 && timeout_cnt == 8'd0; c++) @(negedge clk);
      check("wd_cnt", timeout_cnt, 8'd1);
      wait_req(5);
      check("wd_addr", sdram_addr, got);
      slot0_cs = 1'b0;
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
